// File: rtl/regfile_3r1w_if.sv
// regfile_3r1w_if: read/write bus bundle for regfile_3r1w
// master drives: rd_addr0..2, wr_en, wr_addr, wr_data, pc_in
// slave drives: rd_data0..2, ready
interface regfile_3r1w_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] rd_addr0, rd_addr1, rd_addr2, wr_addr;
  logic [DATA_W-1:0] rd_data0, rd_data1, rd_data2, wr_data, pc_in;
  logic wr_en, ready;
  modport master (
    output rd_addr0, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, pc_in,
    input rd_data0, rd_data1, rd_data2, ready
  );
  modport slave (
    input rd_addr0, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, pc_in,
    output rd_data0, rd_data1, rd_data2, ready
  );
endinterface

// File: rtl/regfile_3r1w.sv
// regfile_3r1w: 3-read/1-write register file with self-clearing startup sweep and PC read alias
// ports: clk, rst (sync, active-high), bus (regfile_3r1w_if.slave: three combinational
//   read ports, one write port, pc_in, ready)
// optional macro REGFILE_BYPASS_EN: same-cycle write-to-read forwarding
module regfile_3r1w #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 15,
  parameter int ADDR_W   = 4,
  parameter int PC_ADDR  = 15
) (
  input logic clk,
  input logic rst,
  regfile_3r1w_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CLEAR, READY} state_t;
  localparam logic [ADDR_W-1:0] NR   = ADDR_W'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] PCA  = ADDR_W'(PC_ADDR);
  state_t state, state_nx;
  logic [ADDR_W-1:0] idx, idx_nx;
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic rdy, clr, wr_ok;
  logic [ADDR_W-1:0] ra [3];
  logic [DATA_W-1:0] rd [3];
  logic [2:0] byp;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end
  // the final sweep edge clears the last register and enters READY together
  always_comb begin
    state_nx = state;
    idx_nx   = '0;
    state_nx = state == IDLE ? CLEAR :
               state == CLEAR ? (idx == LAST ? READY : CLEAR) :
               state == READY ? READY : IDLE;
    idx_nx   = state == CLEAR ? idx + 1'b1 : '0;
  end
  assign rdy   = state == READY;
  assign clr   = state == CLEAR;
  assign wr_ok = rdy && bus.wr_en && bus.wr_addr < NR && bus.wr_addr != PCA;
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr) regs[idx] <= '0;
      else if (wr_ok) regs[bus.wr_addr] <= bus.wr_data;
    end
  end
  assign ra[0] = bus.rd_addr0;
  assign ra[1] = bus.rd_addr1;
  assign ra[2] = bus.rd_addr2;
  for (genvar i = 0; i < 3; i++) begin : g_rd
`ifdef REGFILE_BYPASS_EN
    assign byp[i] = wr_ok && bus.wr_addr == ra[i];
`else
    assign byp[i] = 1'b0;
`endif
    assign rd[i] = !rdy ? '0 :
                   byp[i] ? bus.wr_data :
                   ra[i] < NR ? regs[ra[i]] :
                   ra[i] == PCA ? bus.pc_in : '0;
  end
  assign bus.rd_data0 = rd[0];
  assign bus.rd_data1 = rd[1];
  assign bus.rd_data2 = rd[2];
  assign bus.ready    = rdy;
endmodule

// File: tb/tb_regfile_3r1w.sv
// tb_regfile_3r1w: scoreboard bench for regfile_3r1w against a behavioural model
module tb_regfile_3r1w;
  localparam int DW = 32, AW = 4, NR = 15, PCA = 15;
  typedef struct packed {
    logic rdy;
    logic [DW-1:0] d0, d1, d2;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  regfile_3r1w_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  regfile_3r1w #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .PC_ADDR(PCA)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  exp_t q[$];
  int compared = 0, mismatched = 0;
  logic [DW-1:0] mem [NR];
  int run = 0;
  function automatic logic model_ready();
    return run >= NR + 1;
  endfunction
  function automatic logic [DW-1:0] model_rd(logic [AW-1:0] a);
    if (!model_ready()) return '0;
`ifdef REGFILE_BYPASS_EN
    if (bus.wr_en && bus.wr_addr == a && int'(bus.wr_addr) < NR && int'(bus.wr_addr) != PCA)
      return bus.wr_data;
`endif
    if (int'(a) < NR) return mem[a];
    if (int'(a) == PCA) return bus.pc_in;
    return '0;
  endfunction
  function automatic void chk(string n, logic [DW-1:0] act, logic [DW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ready", DW'(bus.ready), DW'(e.rdy));
      chk("rd_data0", bus.rd_data0, e.d0);
      chk("rd_data1", bus.rd_data1, e.d1);
      chk("rd_data2", bus.rd_data2, e.d2);
    end
  end
  // queue the expected view for this cycle, then apply the clock edge to the model
  task automatic step();
    logic was_ready;
    q.push_back('{rdy: model_ready(), d0: model_rd(bus.rd_addr0),
                  d1: model_rd(bus.rd_addr1), d2: model_rd(bus.rd_addr2)});
    was_ready = model_ready();
    @(posedge clk);
    if (!rst && was_ready && bus.wr_en && int'(bus.wr_addr) < NR && int'(bus.wr_addr) != PCA)
      mem[bus.wr_addr] = bus.wr_data;
    if (rst) run = 0;
    else if (run < NR + 1) begin
      run++;
      if (run == NR + 1) foreach (mem[i]) mem[i] = '0;
    end
    #1;
  endtask
  task automatic drive(input logic [AW-1:0] a0, a1, a2, input logic we,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    bus.rd_addr0 = a0;
    bus.rd_addr1 = a1;
    bus.rd_addr2 = a2;
    bus.wr_en    = we;
    bus.wr_addr  = wa;
    bus.wr_data  = wd;
  endtask
  task automatic read_all();
    for (int i = 0; i < NR; i++) begin
      drive(AW'(i), AW'(i), AW'(i), 1'b0, '0, '0);
      step();
    end
  endtask
  initial begin
    foreach (mem[i]) mem[i] = '0;
    drive('0, '0, '0, 1'b0, '0, '0);
    bus.pc_in = '0;
    rst = 1;
    @(posedge clk);
    #1;
    step();
    step();
    rst = 0;
    repeat (16) step();
    read_all();
    drive(4'd0, 4'd0, 4'd0, 1'b1, 4'd3, 32'hDEADBEEF);
    step();
    drive(4'd3, 4'd3, 4'd3, 1'b0, '0, '0);
    step();
    bus.pc_in = 32'h0000_0100;
    drive(4'd15, 4'd3, 4'd15, 1'b0, '0, '0);
    step();
    drive(4'd15, 4'd3, 4'd0, 1'b1, 4'd15, 32'h55);
    step();
    read_all();
    drive(4'd7, 4'd7, 4'd7, 1'b1, 4'd7, 32'h1111_2222);
    step();
    drive(4'd0, 4'd7, 4'd3, 1'b1, 4'd7, 32'h12345678);
    step();
    drive(4'd7, 4'd7, 4'd7, 1'b0, '0, '0);
    step();
    rst = 1;
    step();
    rst = 0;
    drive(4'd4, 4'd4, 4'd4, 1'b0, '0, '0);
    repeat (5) step();
    drive(4'd4, 4'd4, 4'd4, 1'b1, 4'd4, 32'h99);
    step();
    rst = 1;
    drive(4'd4, 4'd4, 4'd4, 1'b0, '0, '0);
    step();
    rst = 0;
    repeat (16) step();
    read_all();
    drive(4'd2, 4'd2, 4'd2, 1'b1, 4'd2, 32'hA5);
    step();
    drive(4'd2, 4'd2, 4'd2, 1'b1, 4'd2, 32'hA5);
    rst = 1;
    step();
    rst = 0;
    drive(4'd2, 4'd2, 4'd2, 1'b0, '0, '0);
    repeat (16) step();
    step();
    repeat (600) begin
      rst = $urandom_range(199) == 0;
      bus.pc_in = $urandom;
      drive(AW'($urandom_range(15)), AW'($urandom_range(15)), AW'($urandom_range(15)),
            $urandom_range(1) == 1, AW'($urandom_range(15)), $urandom);
      step();
    end
    rst = 0;
    drive('0, '0, '0, 1'b0, '0, '0);
    step();
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
